// File: rtl/vslc_pkg.sv
// vslc_pkg: shared definitions for the VSLC SPI instruction fetcher.
//   fetch_state_e     - fetcher FSM states
//   VSLC_SPI_READ_OP  - 25xx EEPROM READ opcode
//   VSLC_ADDR_W       - EEPROM byte address width
package vslc_pkg;

  localparam int         VSLC_ADDR_W      = 16;
  localparam logic [7:0] VSLC_SPI_READ_OP = 8'h03;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_CMD,
    FETCH_ADDR,
    FETCH_DATA,
    FETCH_HOLD,
    FETCH_DESELECT
  } fetch_state_e;

endpackage

// File: rtl/vslc_spi_fetch_if.sv
// vslc_spi_fetch_if: byte stream from the fetcher to the VSLC core.
//   instr_data  - current program byte
//   instr_valid - instr_data is valid
//   instr_ready - core accepts the byte
//   instr_addr  - EEPROM address of instr_data
// master = fetcher, slave = core.
interface vslc_spi_fetch_if;
  import vslc_pkg::*;

  logic [7:0]             instr_data;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [VSLC_ADDR_W-1:0] instr_addr;

  modport master (
    output instr_data,
    output instr_valid,
    output instr_addr,
    input  instr_ready
  );

  modport slave (
    input  instr_data,
    input  instr_valid,
    input  instr_addr,
    output instr_ready
  );

endinterface

// File: rtl/vslc_spi_tick.sv
// vslc_spi_tick: free-running divider, one-cycle tick every 2**SPI_CLK_DIV
// clk cycles.
//   clk, rst - clock, asynchronous active-high reset
//   clr      - restart the phase; the first tick then follows H cycles later
//   tick     - one-cycle strobe, marks an SCK half-period boundary
module vslc_spi_tick #(
  parameter int SPI_CLK_DIV = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [SPI_CLK_DIV-1:0] cnt;

  assign tick = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + SPI_CLK_DIV'(1);
    end
  end

endmodule

// File: rtl/vslc_spi_fetch.sv
// vslc_spi_fetch: streams the ladder program out of a 25xx SPI EEPROM
// (READ 0x03 + 16-bit address) and hands it to the core byte by byte.
// Backpressure parks SCK low in HOLD, so one transaction spans the scan.
//   clk, rst       - clock, asynchronous active-high reset
//   start          - pulse: open a read at start_addr (restarts if busy)
//   start_addr     - first byte address, sampled with start
//   stop           - pulse: abort the transaction
//   instr          - byte stream to the core (master modport)
//   busy           - transaction open (any state but IDLE)
//   spi_cs_n, spi_sck, spi_mosi, spi_miso - SPI mode 0 bus
module vslc_spi_fetch
  import vslc_pkg::*;
#(
  parameter int SPI_CLK_DIV     = 3,
  parameter int DESELECT_HALVES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [VSLC_ADDR_W-1:0] start_addr,
  input  logic                   stop,
  vslc_spi_fetch_if.master       instr,
  output logic                   busy,
  output logic                   spi_cs_n,
  output logic                   spi_sck,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  localparam logic [4:0] DESEL_LAST = 5'(DESELECT_HALVES - 1);

  fetch_state_e           state, state_nxt;
  logic                   tick, tick_clr;
  logic                   load_cmd, abort, accept;
  logic                   shifting, rise, fall;
  logic                   sck_q, pending;
  logic [4:0]             bit_cnt;
  logic [23:0]            tx_sh;
  logic [7:0]             rx_sh;
  logic [VSLC_ADDR_W-1:0] addr_src;

  vslc_spi_tick #(.SPI_CLK_DIV(SPI_CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign shifting = (state == FETCH_CMD) || (state == FETCH_ADDR) || (state == FETCH_DATA);
  assign rise     = shifting & tick & ~sck_q;
  assign fall     = shifting & tick & sck_q;
  // A start on the very cycle DESELECT ends must use the new address.
  assign addr_src = start ? start_addr : instr.instr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tick_clr  = 1'b0;
    load_cmd  = 1'b0;
    abort     = 1'b0;
    accept    = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (start) begin
          state_nxt = FETCH_CMD;
          load_cmd  = 1'b1;
          tick_clr  = 1'b1;
        end
      end
      FETCH_DESELECT: begin
        // The divider wraps to phase 0 on this tick, so CMD starts aligned.
        if (tick && bit_cnt == DESEL_LAST) begin
          if (pending || start) begin
            state_nxt = FETCH_CMD;
            load_cmd  = 1'b1;
          end else begin
            state_nxt = FETCH_IDLE;
          end
        end
      end
      default: begin
        if (start || stop) begin
          state_nxt = FETCH_DESELECT;
          abort     = 1'b1;
          tick_clr  = 1'b1;
        end else begin
          case (state)
            FETCH_CMD:  if (fall && bit_cnt == 5'd7)  state_nxt = FETCH_ADDR;
            FETCH_ADDR: if (fall && bit_cnt == 5'd23) state_nxt = FETCH_DATA;
            FETCH_DATA: if (fall && bit_cnt == 5'd7)  state_nxt = FETCH_HOLD;
            FETCH_HOLD: begin
              if (instr.instr_ready) begin
                state_nxt = FETCH_DATA;
                accept    = 1'b1;
              end else begin
                // Pin the divider while stalled so the next rising edge
                // lands H cycles after the handshake.
                tick_clr = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q            <= 1'b0;
      bit_cnt          <= '0;
      pending          <= 1'b0;
      instr.instr_data <= '0;
      instr.instr_addr <= '0;
    end else begin
      if (abort)                 sck_q <= 1'b0;
      else if (shifting && tick) sck_q <= ~sck_q;

      // CMD and ADDR share one 0..23 count; DATA and DESELECT restart at 0.
      if (load_cmd || abort) begin
        bit_cnt <= '0;
      end else if (fall || (state == FETCH_DESELECT && tick)) begin
        bit_cnt <= (state_nxt != state && state != FETCH_CMD) ? 5'd0 : bit_cnt + 5'd1;
      end

      if (load_cmd)                         pending <= 1'b0;
      else if (start && state != FETCH_IDLE) pending <= 1'b1;

      if (start)       instr.instr_addr <= start_addr;
      else if (accept) instr.instr_addr <= instr.instr_addr + VSLC_ADDR_W'(1);

      if (fall && state == FETCH_DATA && bit_cnt == 5'd7) instr.instr_data <= rx_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (load_cmd)  tx_sh <= {VSLC_SPI_READ_OP, addr_src};
    else if (fall) tx_sh <= {tx_sh[22:0], 1'b0};
    if (rise && state == FETCH_DATA) rx_sh <= {rx_sh[6:0], spi_miso};
  end

  assign instr.instr_valid = (state == FETCH_HOLD);
  assign busy              = (state != FETCH_IDLE);
  assign spi_cs_n          = (state == FETCH_IDLE) || (state == FETCH_DESELECT);
  assign spi_sck           = sck_q;
  assign spi_mosi          = ((state == FETCH_CMD) || (state == FETCH_ADDR)) & tx_sh[23];

endmodule

// File: doc/vslc_spi_fetch.md
# vslc_spi_fetch

Streaming instruction fetcher that sits directly upstream of the VSLC core. It reads the ladder program from an external 25xx-series SPI EEPROM using the READ command (0x03) and a 16-bit address. It then delivers program bytes one at a time to the core over a valid/ready handshake. Backpressure stalls SCK, so a transaction stays open for the whole scan and only ends on `stop` or a restart.

## Interface
- `SPI_CLK_DIV`, default 3: SCK half-period H = 2**SPI_CLK_DIV `clk` cycles.
- `DESELECT_HALVES`, default 2: minimum CS-high time, in units of H.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; opens a read at `start_addr`, restarting if busy.
- `start_addr`  in  16  first byte address, sampled when `start` is high.
- `stop`  in  1  one-cycle pulse; aborts the transaction.
- `instr_data`  out  8  current program byte.
- `instr_valid`  out  1  `instr_data` is valid.
- `instr_ready`  in  1  core accepts the byte.
- `instr_addr`  out  16  EEPROM address of `instr_data`.
- `busy`  out  1  high from the cycle after an accepted `start` until the return to IDLE.
- `spi_cs_n`  out  1  chip select, active low.
- `spi_sck`  out  1  SPI clock, mode 0.
- `spi_mosi`  out  1  serial data to the EEPROM, MSB first.
- `spi_miso`  in  1  serial data from the EEPROM.

## Operation
- States:
  - IDLE
  - CMD: 8 bits, 0x03
  - ADDR: 16 bits
  - DATA: 8 bits
  - HOLD: byte presented, waiting for `instr_ready`
  - DESELECT
- Transitions:
  - IDLE -start-> CMD
  - CMD -> ADDR -> DATA
  - DATA -> HOLD after the 8th falling edge
  - HOLD -(valid & ready)-> DATA
  - any non-IDLE state -stop-> DESELECT
  - any non-IDLE state -start-> DESELECT with a restart pending
  - DESELECT -> CMD if a restart is pending, otherwise IDLE, after DESELECT_HALVES*H cycles
- SPI signalling (mode 0):
  - SCK idles low.
  - MOSI is updated while SCK is low, before each rising edge.
  - MISO is sampled on the `clk` cycle SCK rises.
  - MOSI is held at 0 during DATA.
- `instr_addr`:
  - Loads `start_addr` when `start` is accepted.
  - Increments by 1 on each valid & ready handshake.
  - Wraps from 0xFFFF to 0x0000, matching the EEPROM's internal wrap.
- Boundary behaviour:
  - `start` and `stop` in the same cycle: `start` wins (restart).
  - `stop` in IDLE or DESELECT: ignored; a pending restart is not cancelled.
  - `start` during DESELECT: latched as pending, with `start_addr` captured.
  - Abort or restart mid-bit: SCK is forced low the same cycle CS rises; `instr_valid` drops.
- Bit, phase and divider counters are internal only; there is no partial-byte output.

## Timing
- Reset values:
  - `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0
  - `instr_valid`=0, `instr_data`=0x00, `instr_addr`=0x0000
  - `busy`=0, state IDLE, pending cleared
- `start` at cycle s: `spi_cs_n` falls at t0 = s+1, and `busy` rises at t0.
- Bit k of the transaction (k = 0..31 for the first byte):
  - SCK rises at t0 + H + 2H·k.
  - SCK falls at t0 + 2H + 2H·k.
- First byte: `instr_valid` rises at t0 + 64H, the falling edge of bit 31.
  - With the default H=8, this is t0+512.
- Handshake at cycle h:
  - `instr_valid` is low from h+1.
  - The next SCK rising edge is at h+H.
  - The next `instr_valid` rises at h+16H.
- With `instr_ready` tied high, `instr_valid` is a 1-cycle pulse every 16H cycles.
- `instr_data` and `instr_addr` are stable while `instr_valid` is high.
- `stop` at cycle p:
  - `spi_cs_n`=1 and `spi_sck`=0 from p+1.
  - `busy` falls at p+1+DESELECT_HALVES·H.
- Restart: CS is high for exactly DESELECT_HALVES·H cycles, then the CMD timing above applies with t0 = the cycle CS falls.

## Structure
- Package `vslc_pkg` holds:
  - the fetch state enum
  - `VSLC_SPI_READ_OP` = 8'h03
  - `VSLC_ADDR_W` = 16
- Sub-module `vslc_spi_tick`: a free-running divider emitting a one-cycle tick every H cycles. It is reset on transaction start so that phase is deterministic.
- The fetcher keeps:
  - a 24-bit transmit shift register (opcode plus address)
  - an 8-bit receive shift register
  - a 5-bit bit counter

## Test plan
- Reset mid-DATA: assert `rst` -> every output takes its reset value that same cycle; SCK does not toggle after release.
- Basic fetch:
  - Stimulus: `start_addr`=0x0123, `start` pulse, EEPROM model returns 0xA5, 0x3C; `instr_ready`=1.
  - MOSI carries 0x03,0x01,0x23.
  - `instr_valid` at t0+512 with `instr_data`=0xA5 and `instr_addr`=0x0123.
  - Next byte 0x3C/0x0124 at +128.
- Backpressure: hold `instr_ready`=0 for 300 cycles -> SCK stays low, `instr_valid`, `instr_data` and `instr_addr` are held, and no byte is lost.
- Wrap: `start_addr`=0xFFFF, accept 2 bytes -> `instr_addr` reads 0xFFFF, then 0x0000.
- Restart and stop:
  - `start` (addr 0x0040) while in HOLD -> CS is high for 16 cycles, then a new 0x03,0x00,0x40 sequence.
  - `start` and `stop` in the same cycle behave identically to `start` alone.
- Stop mid-ADDR: `stop` -> CS high and SCK low next cycle, `busy` low 16 cycles later, and a later `start` works normally.
